i2c_ccd_slave_rx: RTL

- I2C write-only responder that models the CCD sensor end of the configuration bus.
- Accepts 3-byte write frames of the form [slave addr + W, sub-addr, data byte] from the config master.
- Pairs each high-byte frame with a following low-byte frame on sub-addr 0xF1, then issues one 16-bit register write strobe.
- Used in simulation as the sensor model, and on the FPGA as a bus monitor/mirror for the sensor register set.

---
 rtl/i2c_ccd_slave_rx.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_ccd_slave_rx.sv
// Write-only I2C responder modelling the CCD sensor end of the configuration bus.
// Accepts [addr+W, sub-addr, data] frames and pairs a high-byte frame with a
// following low-byte frame on LO_SUBADDR to produce one 16-bit register write.
module i2c_ccd_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5D,
  parameter logic [7:0] LO_SUBADDR = 8'hF1
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic        oWR_EN,
  output logic [7:0]  oWR_ADDR,
  output logic [15:0] oWR_DATA,
  output logic        oBUSY,
  output logic        oPROTO_ERR
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAckA,
    StSub,
    StAckS,
    StData,
    StAckD,
    StExtra,
    StIgnore
  } state_e;

  // Synchronizer and edge-history flops.
  logic scl_m, scl_sync, scl_hist;
  logic sda_m, sda_sync, sda_hist;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  sub_addr_q, sub_addr_d;
  logic        ack_drive_q, ack_drive_d;
  logic        pending_q, pending_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic       frame_incomplete;

  // Two-flop synchronizers plus one history flop; idle bus level is high.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_m    <= 1'b1;
      scl_sync <= 1'b1;
      scl_hist <= 1'b1;
      sda_m    <= 1'b1;
      sda_sync <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_m    <= I2C_SCLK;
      scl_sync <= scl_m;
      scl_hist <= scl_sync;
      sda_m    <= I2C_SDAT;
      sda_sync <= sda_m;
      sda_hist <= sda_sync;
    end
  end

  assign scl_rise  = scl_sync & ~scl_hist;
  assign scl_fall  = ~scl_sync & scl_hist;
  assign start_det = scl_sync & scl_hist & sda_hist & ~sda_sync;
  assign stop_det  = scl_sync & scl_hist & ~sda_hist & sda_sync;
  assign byte_in   = {shift_q[6:0], sda_sync};

  // A STOP is a protocol error mid-byte, or once the sub-address phase has
  // started but before the data byte has been fully received.
  assign frame_incomplete = (state_q == StSub) || (state_q == StAckS) ||
                            (state_q == StData) ||
                            ((state_q == StAddr) && (bit_cnt_q != 4'd0));

  // Protocol state and datapath registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      sub_addr_q  <= 8'd0;
      ack_drive_q <= 1'b0;
      pending_q   <= 1'b0;
      hi_q        <= 8'd0;
      ptr_q       <= 8'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 16'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sub_addr_q  <= sub_addr_d;
      ack_drive_q <= ack_drive_d;
      pending_q   <= pending_d;
      hi_q        <= hi_d;
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit/ACK handling.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sub_addr_d  = sub_addr_q;
    ack_drive_d = ack_drive_q;
    pending_d   = pending_q;
    hi_d        = hi_q;
    ptr_d       = ptr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    err_d       = err_q;

    if (start_det) begin
      // Also covers repeated START; pending pair survives.
      state_d     = StAddr;
      bit_cnt_d   = 4'd0;
      ack_drive_d = 1'b0;
      busy_d      = 1'b1;
    end else if (stop_det) begin
      if (frame_incomplete) begin
        err_d = 1'b1;
      end
      state_d     = StIdle;
      bit_cnt_d   = 4'd0;
      ack_drive_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        StAddr, StSub, StData: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == StAddr) begin
                if ((byte_in[7:1] == SLAVE_ADDR) && !byte_in[0]) begin
                  state_d = StAckA;
                end else begin
                  state_d = StIgnore;
                end
              end else if (state_q == StSub) begin
                sub_addr_d = byte_in;
                state_d    = StAckS;
              end else begin
                state_d = StAckD;
              end
            end
          end
        end
        StAckA, StAckS, StAckD: begin
          // First fall after the 8th bit grabs SDA; the next fall releases it.
          if (scl_fall) begin
            if (!ack_drive_q) begin
              ack_drive_d = 1'b1;
            end else begin
              ack_drive_d = 1'b0;
              bit_cnt_d   = 4'd0;
              if (state_q == StAckA) begin
                state_d = StSub;
              end else if (state_q == StAckS) begin
                state_d = StData;
              end else begin
                state_d = StExtra;
              end
            end
          end
          // Commit on the 9th rising edge of the data byte.
          if ((state_q == StAckD) && ack_drive_q && scl_rise) begin
            if (sub_addr_q != LO_SUBADDR) begin
              ptr_d     = sub_addr_q;
              hi_d      = shift_q;
              pending_d = 1'b1;
            end else if (pending_q) begin
              wr_addr_d = ptr_q;
              wr_data_d = {hi_q, shift_q};
              wr_en_d   = 1'b1;
              pending_d = 1'b0;
            end
          end
        end
        default: begin
          // Idle, Extra and Ignore only react to START/STOP.
        end
      endcase
    end
  end

  // Open-drain: only ever pull low.
  assign I2C_SDAT   = ack_drive_q ? 1'b0 : 1'bz;
  assign oWR_EN     = wr_en_q;
  assign oWR_ADDR   = wr_addr_q;
  assign oWR_DATA   = wr_data_q;
  assign oBUSY      = busy_q;
  assign oPROTO_ERR = err_q;

endmodule
